// File: rtl/alu_ctrl_mc.sv
// ---------------------------------------------------------------------------
// alu_ctrl_mc
//
// Multi-cycle ALU control unit for the multicycle MIPS datapath. Decodes the
// ALUOp / funct / immediate-class flags into a registered ALU operation code,
// and sequences iterative multiply/divide operations, stalling upstream with
// `busy` until HI/LO is ready.
//
// Parameters
//   CON_W      ALU control code width (>= 4; bits above 3 are always 0)
//   MUL_CYCLES cycles a mult/multu occupies the mul/div unit (>= 2)
//   DIV_CYCLES cycles a div/divu occupies the mul/div unit (>= 2)
//   CNT_W      cycle counter width, 2**CNT_W > max(MUL_CYCLES, DIV_CYCLES)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   valid      in   decode fields valid this cycle
//   ALUOp      in   00 lw/sw, 01 beq, 10 R-type, 11 immediate ALU
//   funct      in   R-type function field
//   andi/ori/addi in immediate-class flags (ALUOp = 11)
//   ALUCon     out  registered ALU operation code
//   md_start   out  one-cycle start pulse to the mul/div unit
//   md_signed  out  signed mul/div, held for the whole operation
//   busy       out  mul/div in progress, upstream must stall
//   done       out  one-cycle pulse on the last mul/div cycle
//   hilo_we    out  HI/LO write enable, coincident with done
//   illegal    out  one-cycle pulse on an unrecognised funct / imm class
//
// Every output comes straight from a register; there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module alu_ctrl_mc #(
  parameter int CON_W      = 4,
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic             andi,
  input  logic             ori,
  input  logic             addi,
  output logic [CON_W-1:0] ALUCon,
  output logic             md_start,
  output logic             md_signed,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic             illegal
);

  // ALU operation encodings
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  // Counter reload values: the counter starts at C-1 and the operation ends
  // on the edge after it reads 1, giving exactly C-1 busy cycles.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    MULDIV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_start_q, md_start_d;
  logic             md_signed_q, md_signed_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  // -------------------------------------------------------------------------
  // Field decode (pure function of the current inputs)
  // -------------------------------------------------------------------------
  logic       dec_ok;   // recognised operation
  logic       dec_md;   // mult/multu/div/divu
  logic       dec_div;  // div/divu (selects the reload value)
  logic [3:0] dec_op;

  always_comb begin
    dec_ok  = 1'b1;
    dec_md  = 1'b0;
    dec_div = 1'b0;
    dec_op  = OP_ADD;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100100:            dec_op = OP_AND;
          6'b100101:            dec_op = OP_OR;
          6'b100000, 6'b100001: dec_op = OP_ADD;
          6'b100010, 6'b100011: dec_op = OP_SUB;
          6'b101010:            dec_op = OP_SLT;
          6'b100111:            dec_op = OP_NOR;
          6'b011000, 6'b011001: begin
            dec_op = OP_MULT;
            dec_md = 1'b1;
          end
          6'b011010, 6'b011011: begin
            dec_op  = OP_DIV;
            dec_md  = 1'b1;
            dec_div = 1'b1;
          end
          default:              dec_ok = 1'b0;
        endcase
      end
      default: begin
        // Immediate class, priority andi > ori > addi
        if (andi) begin
          dec_op = OP_AND;
        end else if (ori) begin
          dec_op = OP_OR;
        end else if (addi) begin
          dec_op = OP_ADD;
        end else begin
          dec_ok = 1'b0;
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    md_start_d  = 1'b0;
    md_signed_d = md_signed_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    illegal_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          if (!dec_ok) begin
            // Unrecognised request: code is left untouched
            illegal_d = 1'b1;
          end else begin
            op_d = dec_op;
            if (dec_md) begin
              state_d     = MULDIV;
              md_start_d  = 1'b1;
              // funct[0] distinguishes the unsigned variants (multu/divu)
              md_signed_d = ~funct[0];
              busy_d      = 1'b1;
              cnt_d       = dec_div ? DIV_LOAD : MUL_LOAD;
            end
          end
        end
      end

      MULDIV: begin
        // Requests are ignored entirely while the unit is occupied.
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          md_signed_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      cnt_q       <= '0;
      md_start_q  <= 1'b0;
      md_signed_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      md_start_q  <= md_start_d;
      md_signed_q <= md_signed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
    end
  end

  // Zero-extension keeps the bits above 3 at 0 for wider codes.
  assign ALUCon    = CON_W'(op_q);
  assign md_start  = md_start_q;
  assign md_signed = md_signed_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // HI/LO is written exactly on the completion cycle.
  assign hilo_we   = done_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
module tb_alu_ctrl_mc;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [1:0] ALUOp;
  logic [5:0] funct;
  logic       andi, ori, addi;
  logic [3:0] ALUCon;
  logic       md_start, md_signed, busy, done, hilo_we, illegal;

  int total = 0;
  int bad   = 0;

  alu_ctrl_mc #(
    .CON_W(4), .MUL_CYCLES(32), .DIV_CYCLES(34), .CNT_W(6)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp), .funct(funct),
    .andi(andi), .ori(ori), .addi(addi), .ALUCon(ALUCon),
    .md_start(md_start), .md_signed(md_signed), .busy(busy), .done(done),
    .hilo_we(hilo_we), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [5:0] f);
    valid = 1'b1; ALUOp = 2'b10; funct = f; andi = 0; ori = 0; addi = 0;
  endtask

  int busy_cnt;
  int start_cnt;
  int found;
  int held_bad;
  int seen;

  initial begin
    reset = 1'b1; valid = 1'b0; ALUOp = 2'b00; funct = 6'd0;
    andi = 1'b0; ori = 1'b0; addi = 1'b0;
    step(); step();

    // Reset state
    chk("rst_alucon",  {28'd0, ALUCon}, 32'h2);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_outputs", {27'd0, md_start, md_signed, done, hilo_we, illegal}, 32'd0);
    reset = 1'b0;

    // slt
    rtype(6'b101010); step();
    chk("slt_alucon",  {28'd0, ALUCon}, 32'h7);
    chk("slt_busy",    {31'd0, busy}, 32'd0);
    chk("slt_illegal", {31'd0, illegal}, 32'd0);

    // nor, lw/sw, beq
    rtype(6'b100111); step();
    chk("nor_alucon", {28'd0, ALUCon}, 32'hC);
    ALUOp = 2'b00; step();
    chk("lw_alucon", {28'd0, ALUCon}, 32'h2);
    ALUOp = 2'b01; step();
    chk("beq_alucon", {28'd0, ALUCon}, 32'h6);

    // Immediate class priority
    ALUOp = 2'b11; andi = 1; ori = 1; addi = 1; step();
    chk("imm_and_prio", {28'd0, ALUCon}, 32'h0);
    andi = 0; step();
    chk("imm_or_prio", {28'd0, ALUCon}, 32'h1);
    ori = 0; step();
    chk("imm_addi", {28'd0, ALUCon}, 32'h2);
    andi = 1; step();
    chk("imm_and", {28'd0, ALUCon}, 32'h0);
    andi = 0; addi = 0; step();
    chk("imm_none_illegal", {31'd0, illegal}, 32'd1);
    chk("imm_none_hold",    {28'd0, ALUCon}, 32'h0);
    valid = 1'b0; step();
    chk("imm_illegal_pulse", {31'd0, illegal}, 32'd0);
    chk("idle_hold",         {28'd0, ALUCon}, 32'h0);

    // mult (signed), MUL_CYCLES = 32
    rtype(6'b011000); step();
    valid = 1'b0;
    chk("mult_start",  {31'd0, md_start}, 32'd1);
    chk("mult_signed", {31'd0, md_signed}, 32'd1);
    chk("mult_alucon", {28'd0, ALUCon}, 32'h8);
    chk("mult_busy0",  {31'd0, busy}, 32'd1);
    busy_cnt = 1; start_cnt = 1; found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (md_start) start_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        found = 1;
        break;
      end
    end
    chk("mult_done_seen",   found, 1);
    chk("mult_busy_cycles", busy_cnt, 31);
    chk("mult_start_once",  start_cnt, 1);
    chk("mult_hilo_we",     {31'd0, hilo_we}, 32'd1);
    chk("mult_busy_fall",   {31'd0, busy}, 32'd0);
    chk("mult_signed_clr",  {31'd0, md_signed}, 32'd0);
    step();
    chk("mult_done_pulse", {30'd0, done, hilo_we}, 32'd0);

    // divu with an 'and' request held throughout
    rtype(6'b011011); step();
    chk("divu_signed", {31'd0, md_signed}, 32'd0);
    chk("divu_alucon", {28'd0, ALUCon}, 32'h9);
    chk("divu_busy",   {31'd0, busy}, 32'd1);
    funct = 6'b100100;
    busy_cnt = 1; found = 0; held_bad = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (busy) busy_cnt++;
      if (ALUCon !== 4'h9 || illegal !== 1'b0) held_bad++;
      if (done) begin
        found = 1;
        break;
      end
    end
    chk("divu_done_seen",   found, 1);
    chk("divu_busy_cycles", busy_cnt, 33);
    chk("divu_ignored",     held_bad, 0);
    chk("divu_hilo_we",     {31'd0, hilo_we}, 32'd1);
    step();
    chk("divu_then_and", {28'd0, ALUCon}, 32'h0);
    chk("divu_after_busy", {31'd0, busy}, 32'd0);
    valid = 1'b0; step();

    // div aborted by reset at cycle 10
    rtype(6'b011010); step();
    valid = 1'b0;
    chk("div_signed", {31'd0, md_signed}, 32'd1);
    for (int i = 0; i < 9; i++) step();
    chk("div_busy_c10", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy",   {31'd0, busy}, 32'd0);
    chk("abort_signed", {31'd0, md_signed}, 32'd0);
    chk("abort_alucon", {28'd0, ALUCon}, 32'h2);
    step();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || hilo_we || busy || md_start) seen++;
    end
    chk("abort_no_done", seen, 0);

    // add then unknown funct
    rtype(6'b100000); step();
    chk("add_alucon", {28'd0, ALUCon}, 32'h2);
    funct = 6'b111111; step();
    chk("unk_illegal", {31'd0, illegal}, 32'd1);
    chk("unk_hold",    {28'd0, ALUCon}, 32'h2);
    valid = 1'b0; step();
    chk("unk_pulse", {31'd0, illegal}, 32'd0);

    // subu, or
    rtype(6'b100011); step();
    chk("subu_alucon", {28'd0, ALUCon}, 32'h6);
    funct = 6'b100101; step();
    chk("or_alucon", {28'd0, ALUCon}, 32'h1);
    valid = 1'b0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
